uart_csr_bank: RTL and testbench
================================

Name: uart_csr_bank

Overview:
Parametrised multi-channel UART CSR bank; successor to the single-channel UART CSR register set.
- Holds BAUD_RATE, CONTROL_0, STATUS_0 and a new INT_EN register for each of NUM_CH UART channels.
- Serves them over a simple request/response CSR bus.
- Adds features the single-channel set lacks: sticky write-1-to-clear (W1C) error bits, per-channel interrupts, and config writes deferred while a channel is busy.
- Sits between the system CSR bus and the NUM_CH UART TX/RX cores.

Parameters:
NUM_CH, 2, number of UART channels (>=1)
DATA_WIDTH, 32, CSR data width (>=8)
BAUD_RST, 5208, baud divisor reset value (9600 baud)
CTRL_RST, 6'b100011, CONTROL_0[5:0] reset value (8 data bits, odd parity, parity enabled)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
csr_req_i  in  1  request valid
csr_we_i  in  1  1=write, 0=read
csr_addr_i  in  AW=$clog2(NUM_CH)+2  {channel, reg_idx}
csr_wdata_i  in  DATA_WIDTH  write data
csr_ready_o  out  1  bank can accept a request
csr_rvalid_o  out  1  response strobe (reads and writes)
csr_rdata_o  out  DATA_WIDTH  read data (0 on write responses)
hw_busy_i  in  NUM_CH  channel busy
hw_parity_err_i  in  NUM_CH  one-cycle parity error pulse
hw_dbits_err_i  in  NUM_CH  one-cycle data-bits error pulse
cfg_baud_o  out  NUM_CH*DATA_WIDTH  active baud divisor per channel
cfg_ctrl_o  out  NUM_CH*6  active {data_bits[3:0], odd_parity, parity_en} per channel
irq_o  out  NUM_CH  level interrupt per channel

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Register map per channel (reg_idx): 0 BAUD_RATE RW, 1 CONTROL_0 RW (bits [5:0], upper bits read 0), 2 STATUS_0, 3 INT_EN RW (bit0 parity_err enable, bit1 dbits_err enable).
- STATUS_0 layout: bit0 busy (RO, live hw_busy_i), bit1 parity_err (sticky, W1C), bit2 dbits_err (sticky, W1C), bit3 cfg_pending (RO); all other bits read 0.
- Channel index >= NUM_CH: reads return 0, writes are ignored.
- Bus FSM has two states:
  - IDLE: csr_ready_o=1. Request accepted when csr_req_i=1; address, we and wdata are captured and the write takes effect at the accepting edge. Next state RESP.
  - RESP: csr_ready_o=0, csr_rvalid_o=1 for exactly one cycle with csr_rdata_o. Read data is the register value as of the accepting edge. Always returns to IDLE.
- Throughput: one access per 2 cycles; read latency 1 cycle after acceptance.
- Deferred config:
  - Write to BAUD_RATE or CONTROL_0 while hw_busy_i[ch]=1 goes to a per-channel shadow and sets cfg_pending.
  - On the first cycle hw_busy_i[ch]=0, shadow copies to the active registers (cfg_* update the next cycle) and cfg_pending clears.
  - Write while not busy and not pending updates shadow and active together.
  - Multiple writes while pending: last value wins.
- Readback of BAUD_RATE and CONTROL_0 always returns the shadow (last written) value.
- Sticky errors: a hw pulse sets the bit. When a pulse and a W1C clear of the same bit occur in the same cycle, set wins. Writing 0 has no effect.
- irq_o[ch] = |(STATUS_0[2:1] & INT_EN[1:0]), registered (1-cycle delay after the status bit changes).
- Reset values:
  - csr_ready_o=1, csr_rvalid_o=0, csr_rdata_o=0, irq_o=0.
  - Baud shadow and active = BAUD_RST; control shadow and active = CTRL_RST; INT_EN=0; sticky bits 0; cfg_pending 0; FSM in IDLE.
- Reset mid-operation: any pending response and any pending config are dropped.

Optional Feature:
UART_CSR_ERR_RESP_EN:
- Defined: adds port csr_err_o (out, 1), valid with csr_rvalid_o. It is 1 for: access to channel >= NUM_CH; write to STATUS_0 with csr_wdata_i[0] or csr_wdata_i[3] set; CONTROL_0 write with data_bits outside 5..9. An errored write has no effect at all (W1C bits included). csr_err_o resets to 0.
- Undefined: no csr_err_o port; these accesses are silently accepted. An out-of-range data_bits value is stored as written; RO bits are ignored.

Decomposition:
- Package uart_csr_bank_pkg: reg_idx constants, status bit positions, per-channel control struct {data_bits, odd_parity, parity_en}, INT_EN struct, FSM state enum; reuses the existing parity/error/busy enums.
- Sub-module uart_csr_chan: one channel's shadow/active registers, pending logic, sticky bits and irq. Instantiated NUM_CH times under generate.
- Top level: bus FSM plus read mux.

Test Plan:
- Reset, then read ch0 BAUD_RATE -> rvalid one cycle after acceptance, rdata=5208; cfg_ctrl_o[ch0]=6'b100011.
- hw_busy_i[1]=1; write ch1 BAUD=868 -> readback 868, STATUS_0[3]=1, cfg_baud_o[ch1] stays 5208; drop busy -> next cycle cfg_baud_o[ch1]=868, cfg_pending=0.
- INT_EN ch0=2'b01; pulse hw_parity_err_i[0] -> STATUS_0=0x2, irq_o[0]=1 one cycle later; write STATUS_0=0x2 -> irq_o[0]=0.
- Parity pulse in the same cycle as the W1C write of bit1 -> bit1 stays 1 and irq_o stays high.
- Back-to-back csr_req_i held high -> accepted every other cycle; csr_ready_o=0 during each RESP cycle.
- With UART_CSR_ERR_RESP_EN: write CONTROL_0 data_bits=4 -> csr_err_o=1, register unchanged; read channel NUM_CH -> csr_err_o=1, rdata=0.

Source files
------------

// File: rtl/uart_csr_bank_pkg.sv
// Shared types and constants for the multi-channel UART CSR bank.
// Optional feature macro: UART_CSR_ERR_RESP_EN (error responses on illegal accesses).
package uart_csr_bank_pkg;

    // Register index within a channel's 4-word window
    localparam logic [1:0] REG_BAUD   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_INTEN  = 2'd3;

    // STATUS_0 bit positions
    localparam int unsigned ST_BUSY   = 0;
    localparam int unsigned ST_PARITY = 1;
    localparam int unsigned ST_DBITS  = 2;
    localparam int unsigned ST_PEND   = 3;

    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parity_e;

    typedef struct packed {
        logic [3:0] data_bits;
        parity_e    parity;
        logic       parity_en;
    } ctrl_t;

    typedef struct packed {
        logic dbits_en;
        logic parity_en;
    } int_en_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    // Legal UART frame sizes are 5..9 data bits
    function automatic logic data_bits_ok(input logic [3:0] d);
        return (d >= 4'd5) && (d <= 4'd9);
    endfunction

endpackage

// File: rtl/uart_csr_bank_if.sv
// Request/response CSR bus between the system and the UART CSR bank.
// Optional feature macro: UART_CSR_ERR_RESP_EN adds csr_err_o.
interface uart_csr_bank_if
    import uart_csr_bank_pkg::*;
#(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 32
);
    logic          csr_req_i;
    logic          csr_we_i;
    logic [AW-1:0] csr_addr_i;
    logic [DW-1:0] csr_wdata_i;
    logic          csr_ready_o;
    logic          csr_rvalid_o;
    logic [DW-1:0] csr_rdata_o;
`ifdef UART_CSR_ERR_RESP_EN
    logic          csr_err_o;

    modport master (
        output csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
        input  csr_ready_o, csr_rvalid_o, csr_rdata_o, csr_err_o
    );
    modport slave (
        input  csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
        output csr_ready_o, csr_rvalid_o, csr_rdata_o, csr_err_o
    );
`else
    modport master (
        output csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
        input  csr_ready_o, csr_rvalid_o, csr_rdata_o
    );
    modport slave (
        input  csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
        output csr_ready_o, csr_rvalid_o, csr_rdata_o
    );
`endif
endinterface

// File: rtl/uart_csr_chan.sv
// One UART channel: shadow/active config with busy deferral, sticky W1C
// error bits, interrupt enables and a registered interrupt.
module uart_csr_chan
    import uart_csr_bank_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BAUD_RST   = 5208,
    parameter logic [5:0]  CTRL_RST   = 6'b100011
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [1:0]            reg_idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  busy_i,
    input  logic                  parity_err_i,
    input  logic                  dbits_err_i,
    output logic [DATA_WIDTH-1:0] baud_shadow_o,
    output ctrl_t                 ctrl_shadow_o,
    output int_en_t               int_en_o,
    output logic [3:0]            status_o,
    output logic [DATA_WIDTH-1:0] cfg_baud_o,
    output ctrl_t                 cfg_ctrl_o,
    output logic                  irq_o
);
    logic [DATA_WIDTH-1:0] baud_sh_q, baud_sh_d, baud_act_q;
    ctrl_t                 ctrl_sh_q, ctrl_sh_d, ctrl_act_q;
    int_en_t               int_en_q, int_en_d;
    logic                  par_q, par_d, dbits_q, dbits_d, pend_q, pend_d, irq_q;
    logic                  cfg_wr, par_clr, dbits_clr;

    // Decode the write; a hw pulse overrides a simultaneous W1C clear
    always_comb begin
        baud_sh_d = baud_sh_q;
        ctrl_sh_d = ctrl_sh_q;
        int_en_d  = int_en_q;
        cfg_wr    = 1'b0;
        par_clr   = 1'b0;
        dbits_clr = 1'b0;
        if (wr_en_i) begin
            case (reg_idx_i)
                REG_BAUD: begin
                    baud_sh_d = wdata_i;
                    cfg_wr    = 1'b1;
                end
                REG_CTRL: begin
                    ctrl_sh_d = ctrl_t'(wdata_i[5:0]);
                    cfg_wr    = 1'b1;
                end
                REG_STATUS: begin
                    par_clr   = wdata_i[ST_PARITY];
                    dbits_clr = wdata_i[ST_DBITS];
                end
                default: int_en_d = int_en_t'(wdata_i[1:0]);
            endcase
        end
        par_d   = parity_err_i | (par_q & ~par_clr);
        dbits_d = dbits_err_i | (dbits_q & ~dbits_clr);
        pend_d  = busy_i & (pend_q | cfg_wr);
    end

    // Active config follows the shadow on every idle cycle; while idle and not
    // pending the two are equal, so this covers both direct and deferred writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_sh_q  <= DATA_WIDTH'(BAUD_RST);
            baud_act_q <= DATA_WIDTH'(BAUD_RST);
            ctrl_sh_q  <= ctrl_t'(CTRL_RST);
            ctrl_act_q <= ctrl_t'(CTRL_RST);
            int_en_q   <= '0;
            par_q      <= 1'b0;
            dbits_q    <= 1'b0;
            pend_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            baud_sh_q <= baud_sh_d;
            ctrl_sh_q <= ctrl_sh_d;
            int_en_q  <= int_en_d;
            par_q     <= par_d;
            dbits_q   <= dbits_d;
            pend_q    <= pend_d;
            if (!busy_i) begin
                baud_act_q <= baud_sh_d;
                ctrl_act_q <= ctrl_sh_d;
            end
            irq_q <= (par_q & int_en_q.parity_en) | (dbits_q & int_en_q.dbits_en);
        end
    end

    assign baud_shadow_o = baud_sh_q;
    assign ctrl_shadow_o = ctrl_sh_q;
    assign int_en_o      = int_en_q;
    assign status_o      = {pend_q, dbits_q, par_q, busy_i};
    assign cfg_baud_o    = baud_act_q;
    assign cfg_ctrl_o    = ctrl_act_q;
    assign irq_o         = irq_q;

endmodule

// File: rtl/uart_csr_bank.sv
// Multi-channel UART CSR bank: two-state bus FSM, read mux, NUM_CH channels.
// Optional feature macro: UART_CSR_ERR_RESP_EN (error response, errored writes dropped).
module uart_csr_bank
    import uart_csr_bank_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BAUD_RST   = 5208,
    parameter logic [5:0]  CTRL_RST   = 6'b100011
)(
    input  logic                         clk,
    input  logic                         rst_n,
    uart_csr_bank_if.slave               csr,
    input  logic [NUM_CH-1:0]            hw_busy_i,
    input  logic [NUM_CH-1:0]            hw_parity_err_i,
    input  logic [NUM_CH-1:0]            hw_dbits_err_i,
    output logic [NUM_CH*DATA_WIDTH-1:0] cfg_baud_o,
    output logic [NUM_CH*6-1:0]          cfg_ctrl_o,
    output logic [NUM_CH-1:0]            irq_o
);
    localparam int unsigned AW = $clog2(NUM_CH) + 2;

    state_t                state_q;
    logic                  ready_q, rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
`ifdef UART_CSR_ERR_RESP_EN
    logic                  err_q;
`endif

    logic [AW-1:0]         ch_sel;
    logic [1:0]            reg_idx;
    logic                  accept, err_c;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [NUM_CH-1:0]     wr_en;

    logic [DATA_WIDTH-1:0] baud_sh [NUM_CH];
    ctrl_t                 ctrl_sh [NUM_CH];
    int_en_t               int_en  [NUM_CH];
    logic [3:0]            status  [NUM_CH];

    assign ch_sel  = csr.csr_addr_i >> 2;
    assign reg_idx = csr.csr_addr_i[1:0];
    assign accept  = (state_q == S_IDLE) && csr.csr_req_i;

`ifdef UART_CSR_ERR_RESP_EN
    // Flag out-of-range channels, writes touching RO status bits, illegal frame sizes
    always_comb begin
        err_c = !(ch_sel < AW'(NUM_CH));
        if (csr.csr_we_i && reg_idx == REG_STATUS &&
            (csr.csr_wdata_i[ST_BUSY] || csr.csr_wdata_i[ST_PEND]))
            err_c = 1'b1;
        if (csr.csr_we_i && reg_idx == REG_CTRL && !data_bits_ok(csr.csr_wdata_i[5:2]))
            err_c = 1'b1;
    end
`else
    assign err_c = 1'b0;
`endif

    // Per-channel write strobe at the accepting edge; out-of-range matches nothing
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++)
            wr_en[c] = accept && csr.csr_we_i && !err_c && (ch_sel == AW'(c));
    end

    // Read mux over the addressed channel; unmatched channels read 0
    always_comb begin
        rd_mux = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_sel == AW'(c)) begin
                case (reg_idx)
                    REG_BAUD:   rd_mux = baud_sh[c];
                    REG_CTRL:   rd_mux = DATA_WIDTH'(ctrl_sh[c]);
                    REG_STATUS: rd_mux = DATA_WIDTH'(status[c]);
                    default:    rd_mux = DATA_WIDTH'(int_en[c]);
                endcase
            end
        end
    end

    // Bus FSM: accept in IDLE, one-cycle response strobe in RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
`ifdef UART_CSR_ERR_RESP_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (csr.csr_req_i) begin
                        state_q  <= S_RESP;
                        ready_q  <= 1'b0;
                        rvalid_q <= 1'b1;
                        rdata_q  <= csr.csr_we_i ? '0 : rd_mux;
`ifdef UART_CSR_ERR_RESP_EN
                        err_q    <= err_c;
`endif
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    ready_q  <= 1'b1;
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
`ifdef UART_CSR_ERR_RESP_EN
                    err_q    <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign csr.csr_ready_o  = ready_q;
    assign csr.csr_rvalid_o = rvalid_q;
    assign csr.csr_rdata_o  = rdata_q;
`ifdef UART_CSR_ERR_RESP_EN
    assign csr.csr_err_o    = err_q;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        uart_csr_chan #(
            .DATA_WIDTH (DATA_WIDTH),
            .BAUD_RST   (BAUD_RST),
            .CTRL_RST   (CTRL_RST)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .wr_en_i       (wr_en[g]),
            .reg_idx_i     (reg_idx),
            .wdata_i       (csr.csr_wdata_i),
            .busy_i        (hw_busy_i[g]),
            .parity_err_i  (hw_parity_err_i[g]),
            .dbits_err_i   (hw_dbits_err_i[g]),
            .baud_shadow_o (baud_sh[g]),
            .ctrl_shadow_o (ctrl_sh[g]),
            .int_en_o      (int_en[g]),
            .status_o      (status[g]),
            .cfg_baud_o    (cfg_baud_o[g*DATA_WIDTH +: DATA_WIDTH]),
            .cfg_ctrl_o    (cfg_ctrl_o[g*6 +: 6]),
            .irq_o         (irq_o[g])
        );
    end

endmodule

// File: tb/tb_uart_csr_bank.sv
// Self-checking bench for uart_csr_bank with three channels (channel 3 is out of range).
// Optional feature macro: UART_CSR_ERR_RESP_EN.
module tb_uart_csr_bank;
    localparam int NCH = 3;
`ifdef UART_CSR_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    hw_busy = '0, hw_par = '0, hw_db = '0;
    logic [95:0]   cfg_baud;
    logic [17:0]   cfg_ctrl;
    logic [2:0]    irq;

    uart_csr_bank_if #(.AW(4), .DW(32)) bus ();

    uart_csr_bank #(
        .NUM_CH     (NCH),
        .DATA_WIDTH (32),
        .BAUD_RST   (5208),
        .CTRL_RST   (6'b100011)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .csr             (bus),
        .hw_busy_i       (hw_busy),
        .hw_parity_err_i (hw_par),
        .hw_dbits_err_i  (hw_db),
        .cfg_baud_o      (cfg_baud),
        .cfg_ctrl_o      (cfg_ctrl),
        .irq_o           (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Specification-level model: register file, bus response, interrupts
    logic [31:0] m_sh_baud [NCH], m_act_baud [NCH];
    logic [5:0]  m_sh_ctrl [NCH], m_act_ctrl [NCH];
    logic [1:0]  m_ie [NCH];
    logic        m_par [NCH], m_db [NCH], m_pend [NCH], m_irq [NCH];
    logic        m_ready, m_rvalid, m_err, m_valid = 1'b0;
    logic [31:0] m_rdata;

    function automatic logic [31:0] m_read(input int ch, input int idx);
        if (ch >= NCH) return 32'd0;
        case (idx)
            0:       return m_sh_baud[ch];
            1:       return {26'd0, m_sh_ctrl[ch]};
            2:       return {28'd0, m_pend[ch], m_db[ch], m_par[ch], hw_busy[ch]};
            default: return {30'd0, m_ie[ch]};
        endcase
    endfunction

    task automatic model_step();
        int ch, idx;
        logic acc, err, wr, cfgw, irq_n;
        logic [3:0] d;
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_sh_baud[c] = 32'd5208; m_act_baud[c] = 32'd5208;
                m_sh_ctrl[c] = 6'b100011; m_act_ctrl[c] = 6'b100011;
                m_ie[c] = 2'b00; m_par[c] = 1'b0; m_db[c] = 1'b0;
                m_pend[c] = 1'b0; m_irq[c] = 1'b0;
            end
            m_ready = 1'b1; m_rvalid = 1'b0; m_rdata = '0; m_err = 1'b0;
            m_valid = 1'b1;
            return;
        end
        ch  = int'(bus.csr_addr_i[3:2]);
        idx = int'(bus.csr_addr_i[1:0]);
        d   = bus.csr_wdata_i[5:2];
        acc = m_ready && bus.csr_req_i;
        err = ERR_EN && acc && (ch >= NCH ||
              (bus.csr_we_i && idx == 2 && (bus.csr_wdata_i[0] || bus.csr_wdata_i[3])) ||
              (bus.csr_we_i && idx == 1 && (d < 4'd5 || d > 4'd9)));
        wr  = acc && bus.csr_we_i && !err && ch < NCH;
        if (acc) begin
            m_ready = 1'b0; m_rvalid = 1'b1; m_err = err;
            m_rdata = bus.csr_we_i ? 32'd0 : m_read(ch, idx);
        end else begin
            m_ready = 1'b1; m_rvalid = 1'b0; m_err = 1'b0; m_rdata = '0;
        end
        for (int c = 0; c < NCH; c++) begin
            irq_n = (m_par[c] && m_ie[c][0]) || (m_db[c] && m_ie[c][1]);
            cfgw  = 1'b0;
            if (wr && ch == c) begin
                case (idx)
                    0: begin m_sh_baud[c] = bus.csr_wdata_i; cfgw = 1'b1; end
                    1: begin m_sh_ctrl[c] = bus.csr_wdata_i[5:0]; cfgw = 1'b1; end
                    2: begin
                        if (bus.csr_wdata_i[1]) m_par[c] = 1'b0;
                        if (bus.csr_wdata_i[2]) m_db[c] = 1'b0;
                    end
                    default: m_ie[c] = bus.csr_wdata_i[1:0];
                endcase
            end
            if (hw_par[c]) m_par[c] = 1'b1;
            if (hw_db[c])  m_db[c]  = 1'b1;
            if (hw_busy[c]) begin
                if (cfgw) m_pend[c] = 1'b1;
            end else begin
                m_act_baud[c] = m_sh_baud[c];
                m_act_ctrl[c] = m_sh_ctrl[c];
                m_pend[c]     = 1'b0;
            end
            m_irq[c] = irq_n;
        end
    endtask

    // Compare every DUT output against the model on each falling edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("ready", bus.csr_ready_o, m_ready);
            chk("rvalid", bus.csr_rvalid_o, m_rvalid);
            chk("rdata", bus.csr_rdata_o, m_rdata);
`ifdef UART_CSR_ERR_RESP_EN
            chk("err", bus.csr_err_o, m_err);
`endif
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("cfg_baud[%0d]", c), cfg_baud[c*32 +: 32], m_act_baud[c]);
                chk($sformatf("cfg_ctrl[%0d]", c), cfg_ctrl[c*6 +: 6], m_act_ctrl[c]);
                chk($sformatf("irq[%0d]", c), irq[c], m_irq[c]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] dat);
        bus.csr_req_i = 1'b1; bus.csr_we_i = 1'b1;
        bus.csr_addr_i = a; bus.csr_wdata_i = dat;
        tick();
        bus.csr_req_i = 1'b0; bus.csr_we_i = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] dat);
        bus.csr_req_i = 1'b1; bus.csr_we_i = 1'b0; bus.csr_addr_i = a;
        tick();
        bus.csr_req_i = 1'b0;
        dat = bus.csr_rdata_o;
        tick();
    endtask

    logic [31:0] rd;
    int nrv;

    initial begin
        bus.csr_req_i = 1'b0; bus.csr_we_i = 1'b0;
        bus.csr_addr_i = '0; bus.csr_wdata_i = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset values
        bus_read(4'h0, rd);
        chk("rst_baud0_read", rd, 32'd5208);
        chk("rst_cfg_ctrl0", cfg_ctrl[5:0], 6'b100011);

        // Deferred baud write on busy channel 1
        hw_busy[1] = 1'b1;
        bus_write(4'h4, 32'd868);
        bus_read(4'h4, rd);
        chk("busy_baud1_read", rd, 32'd868);
        bus_read(4'h6, rd);
        chk("busy_status1", rd, 32'h9);
        chk("busy_cfg_baud1_hold", cfg_baud[63:32], 32'd5208);
        chk("model_pend1", m_pend[1], 1'b1);
        hw_busy[1] = 1'b0;
        tick();
        chk("idle_cfg_baud1", cfg_baud[63:32], 32'd868);
        bus_read(4'h6, rd);
        chk("idle_status1", rd, 32'h0);

        // Parity interrupt on channel 0
        bus_write(4'h3, 32'h1);
        hw_par[0] = 1'b1;
        tick();
        hw_par[0] = 1'b0;
        chk("irq0_delay", irq[0], 1'b0);
        tick();
        chk("irq0_set", irq[0], 1'b1);
        bus_write(4'h2, 32'h0);
        bus_read(4'h2, rd);
        chk("status0_w0_noeffect", rd, 32'h2);
        bus_write(4'h2, 32'h2);
        chk("irq0_cleared", irq[0], 1'b0);

        // Set wins over a simultaneous W1C clear
        hw_par[0] = 1'b1;
        tick();
        hw_par[0] = 1'b0;
        tick();
        bus.csr_req_i = 1'b1; bus.csr_we_i = 1'b1;
        bus.csr_addr_i = 4'h2; bus.csr_wdata_i = 32'h2; hw_par[0] = 1'b1;
        tick();
        bus.csr_req_i = 1'b0; bus.csr_we_i = 1'b0; hw_par[0] = 1'b0;
        tick();
        bus_read(4'h2, rd);
        chk("setwins_status0", rd, 32'h2);
        chk("setwins_irq0", irq[0], 1'b1);
        bus_write(4'h2, 32'h2);

        // Back-to-back requests: one access every other cycle
        nrv = 0;
        bus.csr_req_i = 1'b1; bus.csr_we_i = 1'b0; bus.csr_addr_i = 4'h0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.csr_rvalid_o) nrv++;
        end
        bus.csr_req_i = 1'b0;
        chk("b2b_rvalid_count", nrv, 3);

        // Data-bits interrupt on channel 2; parity not enabled there
        bus_write(4'hB, 32'h2);
        hw_db[2] = 1'b1; hw_par[2] = 1'b1;
        tick();
        hw_db[2] = 1'b0; hw_par[2] = 1'b0;
        tick();
        chk("irq2_set", irq[2], 1'b1);
        bus_read(4'hA, rd);
        chk("status2_both", rd, 32'h6);
        bus_write(4'hA, 32'h4);
        chk("irq2_cleared", irq[2], 1'b0);
        bus_read(4'hA, rd);
        chk("status2_par_only", rd, 32'h2);

        // Out-of-range channel 3
        bus_write(4'hC, 32'h1234);
        bus_read(4'hC, rd);
        chk("oor_baud_read", rd, 32'h0);
        bus_read(4'hF, rd);
        chk("oor_inten_read", rd, 32'h0);

        // CONTROL_0: upper bits dropped, illegal data_bits handling
        bus_write(4'h1, 32'hFFFF_FF12);
        bus_read(4'h1, rd);
`ifdef UART_CSR_ERR_RESP_EN
        chk("ctrl0_bad_dbits", rd, 32'h23);
`else
        chk("ctrl0_bad_dbits", rd, 32'h12);
`endif
        bus_write(4'h1, 32'h26);
        bus_read(4'h1, rd);
        chk("ctrl0_read", rd, 32'h26);
        chk("ctrl0_cfg", cfg_ctrl[5:0], 6'h26);
        bus_write(4'h2, 32'h9);
        bus_read(4'h2, rd);
        chk("status0_ro_write", rd, 32'h0);

        // Reset mid-operation drops pending config and the pending response
        hw_busy[2] = 1'b1;
        bus_write(4'h8, 32'd100);
        chk("pend_cfg_baud2_hold", cfg_baud[95:64], 32'd5208);
        bus.csr_req_i = 1'b1; bus.csr_we_i = 1'b0; bus.csr_addr_i = 4'h8;
        tick();
        bus.csr_req_i = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_rvalid", bus.csr_rvalid_o, 1'b0);
        chk("model_pend2_rst", m_pend[2], 1'b0);
        tick();
        bus_read(4'hA, rd);
        chk("rst_mid_status2", rd, 32'h1);
        bus_read(4'h8, rd);
        chk("rst_mid_baud2", rd, 32'd5208);
        hw_busy[2] = 1'b0;
        tick();
        chk("rst_mid_cfg_baud2", cfg_baud[95:64], 32'd5208);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
